fifo_reader: RTL
================

Name: fifo_reader

Overview:
- Avalon-MM read master that fetches one 32x32 tile of 16-bit pixels from memory and pushes it, row-major, into a downstream FIFO.
- Mirror of the tile write path: same tile geometry, same stride-based addressing.
- Sits between the memory interconnect and the pixel-processing pipeline; it is also the source side of memory-to-memory tile copies.
- Reads are pipelined, with a bounded number outstanding, and flow-controlled by an internal return buffer.

Parameters:
- MAX_PENDING, 4, maximum reads in flight plus return-buffer occupancy; also the return-buffer depth (power of 2, ≥2).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- stride  in  16  row pitch in bytes, unsigned; sampled every row wrap
- cmd_addr  in  32  tile base byte address; bit 0 ignored (treated as 0)
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- busy  out  1  high from command accept until the last word is pushed
- done  out  1  one-cycle pulse after the final word is pushed
- master_address  out  32  read byte address
- master_read  out  1  read request
- master_wait_request  in  1  Avalon waitrequest
- master_read_data  in  16  returned pixel
- master_read_data_valid  in  1  Avalon readdatavalid
- fifo_data  out  16  pixel to downstream FIFO
- fifo_write  out  1  push strobe
- fifo_full  in  1  downstream FIFO full

Behaviour:
- Reset values:
  - master_read=0, fifo_write=0, done=0, busy=0, cmd_ready=1.
  - master_address=0, fifo_data=0.
  - All counters 0, state IDLE.
- States:
  - IDLE: on accept, latch currAddr={cmd_addr[31:1],0}, col=0, line=0; go to ISSUE.
  - ISSUE: issue reads. A read is accepted when master_read & !master_wait_request. After the read with line=31, col=31 is accepted, go to DRAIN.
  - DRAIN: wait until pending=0 and the return buffer is empty, pulse done, go to IDLE.
- Issue rule:
  - master_read = (state==ISSUE) & (pending + buf_count < MAX_PENDING).
  - While master_read is high and master_wait_request is high, master_address and master_read are held stable.
- Address update on each accepted read:
  - col != 31: addr += 2.
  - col == 31: addr = addr + stride - 62, and line += 1.
  - col always increments mod 32.
  - All arithmetic is 32-bit modulo 2^32 (wraps silently). stride is zero-extended.
- Pending counter:
  - +1 on accepted read, -1 on master_read_data_valid; both in the same cycle leaves it unchanged.
  - Width clog2(MAX_PENDING+1).
- Return buffer:
  - Every master_read_data_valid word is written into the buffer. It cannot overflow, by construction of the issue rule.
  - The head is pushed when !fifo_full: fifo_write=1 and fifo_data=head, combinationally from the buffer.
  - The buffer may be written and read in the same cycle.
- Latency: the first fifo_write can occur one cycle after the first master_read_data_valid (registered buffer write).
- Order: words leave in issue order, exactly 1024 per command. fifo_full stalls issue (via backpressure) and never drops data.
- busy=1 in ISSUE and DRAIN. done pulses for exactly 1 cycle on the DRAIN→IDLE transition.
- cmd_valid while busy is ignored (cmd_ready=0); no queuing.
- Reset mid-tile: everything returns to IDLE and the buffer empties. In-flight read responses are the interconnect's responsibility; the interconnect shares resetn.
- stride < 64 (overlapping rows) is legal and not checked.

Optional Feature:
- FIFO_READER_HEADER_EN
- Defined:
  - After command accept, push two header words before any pixel: cmd_addr[31:16] first, then {cmd_addr[15:1],0}.
  - Each header word waits on !fifo_full.
  - Reads do not issue until both header words are pushed (extra states HDR_HI, HDR_LO between IDLE and ISSUE).
  - Output is then 1026 words/tile, directly consumable by the tile writer for copies.
- Undefined: no header states; 1024 words per tile.

Decomposition:
- Shared package gpu_tile_pkg:
  - TILE_DIM=32, TILE_LOG2=5, PIXEL_W=16, TILE_ROW_BYTES=64.
  - Row-wrap offset constant ROW_WRAP_BYTES=62.
  - State encoding typedef/localparams for reader states.
- One sub-module: fifo_reader_rbuf, a MAX_PENDING-deep synchronous FIFO with count output, asynchronous active-low reset, and simultaneous read/write support.

Test Plan:
- base=0x00001000, stride=64, no stalls:
  - Read addresses are 0x1000..0x17FE contiguous, 1024 pushes in order of the memory model contents.
  - done pulses once; cmd_ready returns to 1.
- base=0x00002000, stride=1024:
  - Row 1 starts at 0x2400; last address is 0x2000+31*1024+62=0x9C3E.
  - Exactly 32 reads per row.
- fifo_full held high for 200 cycles mid-tile, with memory latency 3:
  - pending+buf_count never exceeds 4; no words lost or duplicated.
  - Push resumes the cycle after fifo_full drops.
- master_wait_request randomly high 50%:
  - Address stable across stalled cycles; address sequence is identical to the no-stall run.
- resetn low at word 500, then a new command with base=0xFFFFFFC0, stride=64:
  - Outputs reset immediately.
  - Second tile addresses wrap to 0x00000000 at row 1; done pulses.
- With FIFO_READER_HEADER_EN, cmd_addr=0x12345679:
  - First two pushes are 0x1234, then 0x5678; then 1024 pixels.
  - No master_read before the second header word is pushed.

Source files
------------

// File: rtl/gpu_tile_pkg.sv
// Shared tile geometry and reader state encoding for the GPU tile datapath.
//   TILE_DIM x TILE_DIM tiles of PIXEL_W-bit pixels, stride-addressed rows.
package gpu_tile_pkg;

    localparam int unsigned TILE_DIM       = 32;
    localparam int unsigned TILE_LOG2      = 5;
    localparam int unsigned PIXEL_W        = 16;
    localparam int unsigned TILE_ROW_BYTES = TILE_DIM * (PIXEL_W / 8);
    // Offset from the last pixel of a row back to the row start.
    localparam int unsigned ROW_WRAP_BYTES = TILE_ROW_BYTES - (PIXEL_W / 8);
    localparam int unsigned ADDR_W         = 32;

    typedef enum logic [2:0] {
        RD_IDLE   = 3'd0,
        RD_HDR_HI = 3'd1,
        RD_HDR_LO = 3'd2,
        RD_ISSUE  = 3'd3,
        RD_DRAIN  = 3'd4
    } rd_state_e;

endpackage

// File: rtl/fifo_reader_rbuf.sv
// Return buffer for fifo_reader: DEPTH-deep synchronous FIFO with occupancy.
//   clk, resetn          : clock, asynchronous active-low reset
//   wr_en_i, wr_data_i   : push (caller guarantees no overflow)
//   rd_en_i, rd_data_o   : pop; rd_data_o is the head, valid while count_o != 0
//   count_o              : current occupancy
module fifo_reader_rbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only slots covered by count_q are ever read out.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/fifo_reader.sv
// Tile read master: fetches a 32x32 tile of 16-bit pixels over Avalon-MM and
// pushes it row-major into a downstream FIFO.
//   clk, resetn                 : clock, asynchronous active-low reset
//   stride, cmd_addr, cmd_valid : row pitch (bytes), tile base, command request
//   cmd_ready, busy, done       : command handshake / activity / completion pulse
//   master_*                    : Avalon-MM read master
//   fifo_data, fifo_write       : push side of downstream FIFO, fifo_full backpressure
// Build option FIFO_READER_HEADER_EN: prefix each tile with two header words
// (base address high half, then low half) ahead of the pixels.
module fifo_reader
    import gpu_tile_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] stride,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic        master_wait_request,
    input  logic [15:0] master_read_data,
    input  logic        master_read_data_valid,
    output logic [15:0] fifo_data,
    output logic        fifo_write,
    input  logic        fifo_full
);

    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
    localparam int unsigned OCC_W  = PEND_W + 1;
    localparam logic [TILE_LOG2-1:0] IDX_LAST = TILE_LOG2'(TILE_DIM - 1);

`ifdef FIFO_READER_HEADER_EN
    localparam rd_state_e FIRST_ACTIVE = RD_HDR_HI;
`else
    localparam rd_state_e FIRST_ACTIVE = RD_ISSUE;
`endif

    rd_state_e              state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [TILE_LOG2-1:0]   col_q, col_d;
    logic [TILE_LOG2-1:0]   line_q, line_d;
    logic [PEND_W-1:0]      pending_q, pending_d;
    logic                   done_q, done_d;

    logic [PEND_W-1:0]      buf_count;
    logic [PIXEL_W-1:0]     buf_head;
    logic [OCC_W-1:0]       occ;
    logic                   cmd_fire, rd_fire, last_read, buf_pop;

    assign occ       = OCC_W'(pending_q) + OCC_W'(buf_count);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign rd_fire   = master_read & ~master_wait_request;
    assign last_read = rd_fire & (col_q == IDX_LAST) & (line_q == IDX_LAST);
    assign buf_pop   = (buf_count != '0) & ~fifo_full;

    // Return buffer absorbs every read response; its occupancy gates issue.
    fifo_reader_rbuf #(
        .DEPTH (MAX_PENDING),
        .WIDTH (PIXEL_W)
    ) u_rbuf (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en_i   (master_read_data_valid),
        .wr_data_i (master_read_data),
        .rd_en_i   (buf_pop),
        .rd_data_o (buf_head),
        .count_o   (buf_count)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= RD_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; done fires on the DRAIN->IDLE transition.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            RD_IDLE:   if (cmd_fire) state_d = FIRST_ACTIVE;
`ifdef FIFO_READER_HEADER_EN
            RD_HDR_HI: if (!fifo_full) state_d = RD_HDR_LO;
            RD_HDR_LO: if (!fifo_full) state_d = RD_ISSUE;
`endif
            RD_ISSUE:  if (last_read) state_d = RD_DRAIN;
            RD_DRAIN: begin
                if ((pending_q == '0) && (buf_count == '0)) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:   state_d = RD_IDLE;
        endcase
    end

    // Output decode. Reads stay asserted under waitrequest because occupancy
    // can only fall while no read is accepted.
    always_comb begin
        cmd_ready      = 1'b0;
        busy           = 1'b1;
        master_read    = 1'b0;
        master_address = addr_q;
        done           = done_q;
        fifo_write     = buf_pop;
        fifo_data      = buf_pop ? buf_head : '0;
        case (state_q)
            RD_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            RD_ISSUE:  master_read = (occ < OCC_W'(MAX_PENDING));
`ifdef FIFO_READER_HEADER_EN
            RD_HDR_HI: begin
                fifo_write = ~fifo_full;
                fifo_data  = addr_q[31:16];
            end
            RD_HDR_LO: begin
                fifo_write = ~fifo_full;
                fifo_data  = addr_q[15:0];
            end
`endif
            default: ;
        endcase
    end

    // Address walker and outstanding-read counter.
    always_comb begin
        addr_d    = addr_q;
        col_d     = col_q;
        line_d    = line_q;
        pending_d = pending_q;
        if (cmd_fire) begin
            addr_d = {cmd_addr[31:1], 1'b0};
            col_d  = '0;
            line_d = '0;
        end else if (rd_fire) begin
            col_d = col_q + TILE_LOG2'(1);
            if (col_q == IDX_LAST) begin
                addr_d = addr_q + ADDR_W'(stride) - ADDR_W'(ROW_WRAP_BYTES);
                line_d = line_q + TILE_LOG2'(1);
            end else begin
                addr_d = addr_q + ADDR_W'(2);
            end
        end
        case ({rd_fire, master_read_data_valid})
            2'b10:   pending_d = pending_q + PEND_W'(1);
            2'b01:   pending_d = pending_q - PEND_W'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            col_q     <= '0;
            line_q    <= '0;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            col_q     <= col_d;
            line_q    <= line_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

endmodule
